// File: rtl/scan_driver_if.sv
// Host-side handshake for the scan chain driver: request, write payload,
// captured read payload and status.
interface scan_driver_if #(
  parameter int N_BITS = 20
);
  logic              start;
  logic [N_BITS-1:0] wr_data;
  logic [N_BITS-1:0] rd_data;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output wr_data,
    input  rd_data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  wr_data,
    output rd_data,
    output busy,
    output done
  );
endinterface

// File: rtl/scan_driver.sv
// Two-phase scan chain driver.
// One transaction: capture chip x/y, shift N_BITS bits (new din/addr/sram_sel
// in, captured x/y out), then pulse load to move the scan-in cells onto the
// chip inputs.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   S_IDLE    | waiting for start; wr_data latched on acceptance
//   S_CAPTURE | one bit period with scan_i0o1=1 (parallel capture)
//   S_SHIFT   | N_BITS bit periods, scan_in MSB first, scan_out sampled
//   S_LOAD    | three phases: gap, load pulse, gap
//   S_DONE    | one cycle, done=1, rd_data updated
//
// Bit period = P0 (all low, sample point at its end), P1 (phi), P2 (all low),
// P3 (phib). Every phase lasts DIV clk cycles. All pin outputs are registered
// and set from the phase being entered, so they never glitch.
module scan_driver #(
  parameter int N_BITS = 20,
  parameter int DIV    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  scan_driver_if.slave host,
  output logic        phi,
  output logic        phib,
  output logic        scan_i0o1,
  output logic        load,
  output logic        scan_in,
  input  logic        scan_out
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [1:0]        phase;
  logic [BW-1:0]     bit_idx;
  logic [N_BITS-1:0] sh_reg;
  logic [N_BITS-1:0] rd_shadow;
  logic              so_meta;
  logic              so_sync;

  logic              phase_end;
  logic [1:0]        phase_nxt;
  logic              last_bit;

  assign phase_end = (div_cnt == DW'(DIV - 1));
  assign phase_nxt = phase + 2'd1;
  assign last_bit  = (bit_idx == BW'(N_BITS - 1));

  // scan_out arrives asynchronously from the chain; two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      so_meta <= 1'b0;
      so_sync <= 1'b0;
    end else begin
      so_meta <= scan_out;
      so_sync <= so_meta;
    end
  end

  // Transaction sequencer: state, phase timing and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      phase        <= 2'd0;
      bit_idx      <= '0;
      sh_reg       <= '0;
      rd_shadow    <= '0;
      phi          <= 1'b0;
      phib         <= 1'b0;
      scan_i0o1    <= 1'b0;
      load         <= 1'b0;
      scan_in      <= 1'b0;
      host.rd_data <= '0;
      host.busy    <= 1'b0;
      host.done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.start) begin
            sh_reg    <= host.wr_data;
            state     <= S_CAPTURE;
            div_cnt   <= '0;
            phase     <= 2'd0;
            bit_idx   <= '0;
            host.busy <= 1'b1;
            scan_i0o1 <= 1'b1;
            scan_in   <= 1'b0;
            phi       <= 1'b0;
            phib      <= 1'b0;
          end
        end

        S_CAPTURE, S_SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            phase   <= phase_nxt;
            phi     <= (phase_nxt == 2'd1);
            phib    <= (phase_nxt == 2'd3);
            // Last cycle of P0: first sample lands in the MSB after N_BITS shifts.
            if ((state == S_SHIFT) && (phase == 2'd0)) begin
              rd_shadow <= {rd_shadow[N_BITS-2:0], so_sync};
            end
            if (phase == 2'd3) begin
              if (state == S_CAPTURE) begin
                state     <= S_SHIFT;
                scan_i0o1 <= 1'b0;
                scan_in   <= sh_reg[N_BITS-1];
                sh_reg    <= sh_reg << 1;
              end else if (last_bit) begin
                state   <= S_LOAD;
                scan_in <= 1'b0;
              end else begin
                bit_idx <= bit_idx + BW'(1);
                scan_in <= sh_reg[N_BITS-1];
                sh_reg  <= sh_reg << 1;
              end
            end
          end
        end

        S_LOAD: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + DW'(1);
          end else begin
            div_cnt <= '0;
            phase   <= phase_nxt;
            load    <= (phase_nxt == 2'd1);
            if (phase == 2'd2) begin
              state        <= S_DONE;
              host.done    <= 1'b1;
              host.busy    <= 1'b0;
              host.rd_data <= rd_shadow;
            end
          end
        end

        S_DONE: begin
          host.done <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/scan_driver.md
Name: scan_driver

Overview:
- Host-side controller that drives the on-chip two-phase scan chain.
- The chain has 20 scan-in cells followed by 20 scan-out cells. Cells 0..19 hold {sram_sel, addr[10:0], din[7:0]}. Cells 20..39 hold {y[9:0], x[9:0]}.
- The block generates phi, phib, scan_i0o1, load and scan_in, and samples scan_out.
- One transaction does three things: captures chip x/y, shifts out the captured values while shifting in new din/addr/sram_sel, then pulses load.

Parameters:
- N_BITS, 20: shift count per transaction. This equals both the scan-in cell count and the scan-out cell count.
- DIV, 2: clk cycles per phase. Legal range is DIV >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  transaction request; sampled only in IDLE
- wr_data  input  N_BITS  {sram_sel, addr, din}; wr_data[k] is the value for chain cell k
- rd_data  output  N_BITS  {y, x}; rd_data[k] is the captured value of chain cell N_BITS+k
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at transaction end
- phi  output  1  scan master clock
- phib  output  1  scan slave clock; never high together with phi
- scan_i0o1  output  1  1 = parallel capture of chip outputs, 0 = shift
- load  output  1  transfers scan-in cells to chip inputs
- scan_in  output  1  serial data into chain cell 0
- scan_out  input  1  serial data from chain cell 39; asynchronous, so it passes through a 2-flop synchronizer

Behaviour:
- Reset (asynchronous, immediate): all outputs go to 0, the FSM goes to IDLE, and all counters clear.
  - Reset mid-transaction abandons the transaction. load is never pulsed, so chip inputs keep their previous values.
- Phase counter: counts 0..DIV-1; each phase lasts DIV clk cycles.
- Bit period = four phases:
  - P0: phi=0, phib=0; scan_in stable. Synchronized scan_out is sampled on the last cycle of P0.
  - P1: phi=1.
  - P2: phi=0, phib=0.
  - P3: phib=1.
- States:
  - IDLE: when start=1, latch wr_data into the shift register, set busy=1 on the next cycle, go to CAPTURE.
  - CAPTURE: one bit period with scan_i0o1=1 and scan_in=0. No sample is taken. Go to SHIFT.
  - SHIFT: N_BITS bit periods with scan_i0o1=0; bit index i counts 0..N_BITS-1.
    - scan_in = wr_data[N_BITS-1-i] for the whole period, i.e. MSB first.
    - The P0 sample of period i is written to rd_shadow[N_BITS-1-i].
    - After the last P3, go to LOAD.
  - LOAD: three phases with phi=phib=0 and scan_i0o1=0: gap, then load=1, then gap. Go to DONE.
  - DONE: one cycle. done=1, busy=0, rd_data<=rd_shadow. Return to IDLE.
- Latency: done is asserted exactly (4*(N_BITS+1)+3)*DIV clk cycles after the edge that samples start. This is 174 for the defaults.
- rd_data updates only in DONE and holds between transactions.
- start while busy is ignored. start is accepted again in the first IDLE cycle after DONE, which allows back-to-back transactions.
- wr_data changes after acceptance have no effect on the transaction in progress.
- phi and phib are registered outputs, glitch-free, and never high in the same cycle.
- load is high for exactly DIV cycles, and only while phi=phib=0.
- Each transaction produces N_BITS+1 phi pulses and N_BITS+1 phib pulses.
- scan_out changes after the phib rise in P3. It must be stable by the end of the next P0, which is 2*DIV >= 4 cycles later. That margin is why DIV >= 2 is required.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> phi, phib, scan_i0o1, load, scan_in, busy, done and rd_data are all 0 immediately.
- Single transaction, DIV=2, against a behavioural 40-cell chain model:
  - Stimulus: wr_data=20'hBC596 (sram_sel=1, addr=11'h3C5, din=8'h96); chip x=10'h2AB, y=10'h155.
  - Required: after load, the model shows din=8'h96, addr=11'h3C5, sram_sel=1; rd_data=20'h556AB; done pulses at cycle 174.
- Waveform checks on the same transaction:
  - exactly 21 phi and 21 phib pulses, each 2 cycles long;
  - phi&phib never 1; scan_i0o1=1 only during the first period;
  - one load pulse of 2 cycles.
- start held high through a whole transaction -> a second transaction begins right after done. A start pulse while busy -> ignored, and exactly one done per accepted start.
- rst_n pulse at cycle 60 of a transaction -> outputs clear and load never asserts, so the model's din/addr are unchanged. A following transaction with wr_data=20'h00001 completes and gives din=8'h01.
- DIV=5 with the same data as the single-transaction test -> identical rd_data and chip values, and done at cycle 435.
